// File: rtl/cop_ise_pipe.sv
// Ascon ISE coprocessor: Sigma0..Sigma4 linear layer behind a multi-cycle cop_* handshake.
// Define COP_ISE_RV32B_EN to add the rori_l/rori_h/iornot/andnot helper ops.
module cop_ise_pipe #(
  parameter int XLEN = 32,
  parameter int LAT  = 1
) (
  input  logic            cop_clk,
  input  logic            cop_rst,
  input  logic            cop_valid,
  input  logic            cop_rdywr,
  output logic            cop_ready,
  output logic            cop_wait,
  output logic            cop_wr,
  input  logic [31:0]     cop_insn,
  input  logic [XLEN-1:0] cop_rs1,
  input  logic [XLEN-1:0] cop_rs2,
  output logic [XLEN-1:0] cop_rd
);

  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
`ifdef COP_ISE_RV32B_EN
  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
`endif
  localparam bit         IS32     = (XLEN == 32);
  localparam logic [1:0] CNT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("cop_ise_pipe: XLEN must be 32 or 64");
  end
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("cop_ise_pipe: LAT must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_SIG_LO, OP_SIG_HI, OP_RORI_L, OP_RORI_H, OP_IORNOT, OP_ANDNOT
  } op_t;

  state_t          state, state_n;
  logic [1:0]      cnt, cnt_n;
  logic            accept;
  op_t             op_q, dec_op;
  logic            dec_ok;
  logic [2:0]      idx_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] sig_res;
  logic [63:0]     x64, sig64;

  logic [6:0] opcode, funct;
  assign opcode = cop_insn[6:0];
  assign funct  = cop_insn[31:25];

  logic unused_insn;
  assign unused_insn = ^{cop_insn[24:7]};

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sigma(input logic [63:0] x, input logic [2:0] i);
    case (i)
      3'd0:    return x ^ ror64(x, 19) ^ ror64(x, 28);
      3'd1:    return x ^ ror64(x, 61) ^ ror64(x, 39);
      3'd2:    return x ^ ror64(x, 1)  ^ ror64(x, 6);
      3'd3:    return x ^ ror64(x, 10) ^ ror64(x, 17);
      3'd4:    return x ^ ror64(x, 7)  ^ ror64(x, 41);
      default: return 64'd0;
    endcase
  endfunction

  // Undecoded encodings leave dec_ok low so the core can raise its own trap.
  always_comb begin
    dec_ok = 1'b0;
    dec_op = OP_SIG_LO;
    if (opcode == CUSTOM_1 && funct[4:3] == 2'b00 && funct[2:0] <= 3'd4) begin
      if (funct[6:5] == 2'b00) begin
        dec_ok = 1'b1;
        dec_op = OP_SIG_LO;
      end else if (funct[6:5] == 2'b01 && IS32) begin
        dec_ok = 1'b1;
        dec_op = OP_SIG_HI;
      end
    end
`ifdef COP_ISE_RV32B_EN
    else if (opcode == CUSTOM_0) begin
      if (funct[6:5] == 2'b00) begin
        dec_ok = 1'b1;
        dec_op = OP_RORI_L;
      end else if (funct[6:5] == 2'b01 && IS32) begin
        dec_ok = 1'b1;
        dec_op = OP_RORI_H;
      end
    end else if (opcode == CUSTOM_2) begin
      if (funct == 7'b0000000) begin
        dec_ok = 1'b1;
        dec_op = OP_IORNOT;
      end else if (funct == 7'b0000001) begin
        dec_ok = 1'b1;
        dec_op = OP_ANDNOT;
      end
    end
`endif
  end

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      op_q  <= OP_SIG_LO;
      idx_q <= 3'd0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        op_q  <= dec_op;
        idx_q <= funct[2:0];
        rs1_q <= cop_rs1;
        rs2_q <= cop_rs2;
      end
    end
  end

`ifdef COP_ISE_RV32B_EN
  logic [4:0] sh_q;
  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      sh_q <= 5'd0;
    end else if (accept) begin
      sh_q <= funct[4:0];
    end
  end
`endif

  // XLEN=32 forms the 64-bit Ascon word from {rs2, rs1}; hi/lo halves select the output.
  if (IS32) begin : g_x32
    assign x64     = {rs2_q, rs1_q};
    assign sig64   = sigma(x64, idx_q);
    assign sig_res = (op_q == OP_SIG_HI) ? sig64[63:32] : sig64[31:0];
  end else begin : g_x64
    logic unused_rs2;
    assign unused_rs2 = ^rs2_q;
    assign x64     = rs1_q;
    assign sig64   = sigma(x64, idx_q);
    assign sig_res = sig64[XLEN-1:0];
  end

  always_comb begin
    result = '0;
    case (op_q)
      OP_SIG_LO, OP_SIG_HI: result = sig_res;
`ifdef COP_ISE_RV32B_EN
      OP_RORI_L: begin
        logic [2*XLEN-1:0] dbl_l;
        dbl_l  = {rs1_q, rs1_q} >> sh_q;
        result = dbl_l[XLEN-1:0];
      end
      OP_RORI_H: begin
        logic [2*XLEN-1:0] dbl_h;
        dbl_h  = {rs2_q, rs2_q} >> sh_q;
        result = dbl_h[XLEN-1:0];
      end
      OP_IORNOT: result = rs1_q | ~rs2_q;
      OP_ANDNOT: result = rs1_q & ~rs2_q;
`endif
      default: result = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    cop_ready = 1'b0;
    cop_wait  = 1'b0;
    cop_wr    = 1'b0;
    cop_rd    = '0;
    case (state)
      IDLE: begin
        cop_ready = 1'b1;
        if (cop_valid && dec_ok) begin
          accept = 1'b1;
          if (LAT == 1) begin
            state_n = DONE;
          end else begin
            state_n = BUSY;
            cnt_n   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cop_wait = 1'b1;
        if (cnt == 2'd0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      DONE: begin
        cop_wr   = 1'b1;
        cop_rd   = result;
        cop_wait = ~cop_rdywr;
        if (cop_rdywr) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cop_ise_pipe.sv
// Directed bench for cop_ise_pipe: XLEN=32/LAT=1, XLEN=64/LAT=3 and XLEN=32/LAT=4 instances.
// Define COP_ISE_RV32B_EN to also exercise the helper ops.
module tb_cop_ise_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic a_rst, a_valid, a_rdywr, a_ready, a_wait, a_wr;
  logic [31:0] a_insn, a_rs1, a_rs2, a_rd;
  logic b_rst, b_valid, b_rdywr, b_ready, b_wait, b_wr;
  logic [31:0] b_insn;
  logic [63:0] b_rs1, b_rs2, b_rd;
  logic c_rst, c_valid, c_rdywr, c_ready, c_wait, c_wr;
  logic [31:0] c_insn, c_rs1, c_rs2, c_rd;

  cop_ise_pipe #(.XLEN(32), .LAT(1)) dut_a (
    .cop_clk(clk), .cop_rst(a_rst), .cop_valid(a_valid), .cop_rdywr(a_rdywr),
    .cop_ready(a_ready), .cop_wait(a_wait), .cop_wr(a_wr), .cop_insn(a_insn),
    .cop_rs1(a_rs1), .cop_rs2(a_rs2), .cop_rd(a_rd));

  cop_ise_pipe #(.XLEN(64), .LAT(3)) dut_b (
    .cop_clk(clk), .cop_rst(b_rst), .cop_valid(b_valid), .cop_rdywr(b_rdywr),
    .cop_ready(b_ready), .cop_wait(b_wait), .cop_wr(b_wr), .cop_insn(b_insn),
    .cop_rs1(b_rs1), .cop_rs2(b_rs2), .cop_rd(b_rd));

  cop_ise_pipe #(.XLEN(32), .LAT(4)) dut_c (
    .cop_clk(clk), .cop_rst(c_rst), .cop_valid(c_valid), .cop_rdywr(c_rdywr),
    .cop_ready(c_ready), .cop_wait(c_wait), .cop_wr(c_wr), .cop_insn(c_insn),
    .cop_rs1(c_rs1), .cop_rs2(c_rs2), .cop_rd(c_rd));

  function automatic logic [31:0] mkInsn(input logic [6:0] funct, input logic [6:0] opcode);
    return {funct, 18'd0, opcode};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One LAT=1 transaction on instance A with immediate writeback acceptance.
  task automatic applyStimulus(input string tag, input logic [31:0] insn,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] exp);
    checkOutput({tag, "_ready_pre"}, 64'(a_ready), 64'd1);
    a_insn = insn; a_rs1 = rs1; a_rs2 = rs2; a_rdywr = 1'b1; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    checkOutput({tag, "_wr"}, 64'(a_wr), 64'd1);
    checkOutput({tag, "_rd"}, 64'(a_rd), 64'(exp));
    checkOutput({tag, "_wait"}, 64'(a_wait), 64'd0);
    tick();
    checkOutput({tag, "_ready_post"}, 64'(a_ready), 64'd1);
    checkOutput({tag, "_rd_post"}, 64'(a_rd), 64'd0);
  endtask

  task automatic rejectA(input string tag, input logic [31:0] insn);
    a_insn = insn; a_rs1 = 32'h1; a_rs2 = 32'h0; a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput({tag, "_ready"}, 64'(a_ready), 64'd1);
      checkOutput({tag, "_wr"}, 64'(a_wr), 64'd0);
    end
    a_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 1'b1; a_rdywr = 1'b1; a_insn = mkInsn(7'b0000000, 7'b0101011);
    a_rs1 = 32'h1; a_rs2 = 32'h0;
    b_rst = 1'b1; b_valid = 1'b0; b_rdywr = 1'b1; b_insn = '0; b_rs1 = '0; b_rs2 = '0;
    c_rst = 1'b1; c_valid = 1'b0; c_rdywr = 1'b1; c_insn = '0; c_rs1 = '0; c_rs2 = '0;
    tick();
    tick();
    // Reset wins over a held cop_valid on A.
    checkOutput("rst_a_ready", 64'(a_ready), 64'd1);
    checkOutput("rst_a_wait", 64'(a_wait), 64'd0);
    checkOutput("rst_a_wr", 64'(a_wr), 64'd0);
    checkOutput("rst_a_rd", 64'(a_rd), 64'd0);
    checkOutput("rst_b_ready", 64'(b_ready), 64'd1);
    checkOutput("rst_c_wr", 64'(c_wr), 64'd0);
    a_valid = 1'b0;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();

    $display("[TB] XLEN=32 LAT=1 sigma ops");
    applyStimulus("sig_lo0", mkInsn(7'b0000000, 7'b0101011), 32'h1, 32'h0, 32'h00000001);
    applyStimulus("sig_hi0", mkInsn(7'b0100000, 7'b0101011), 32'h1, 32'h0, 32'h00002010);
    applyStimulus("sig_hi3", mkInsn(7'b0100011, 7'b0101011), 32'h1, 32'h0, 32'h00408000);
    applyStimulus("sig_hi1", mkInsn(7'b0100001, 7'b0101011), 32'h0, 32'h1, 32'h02000009);
    applyStimulus("sig_lo1", mkInsn(7'b0000001, 7'b0101011), 32'h0, 32'h1, 32'h00000000);
    applyStimulus("sig_lo4", mkInsn(7'b0000100, 7'b0101011), 32'h1, 32'h0, 32'h00800001);
    applyStimulus("sig_hi4", mkInsn(7'b0100100, 7'b0101011), 32'h1, 32'h0, 32'h02000000);

    $display("[TB] writeback backpressure");
    a_insn = mkInsn(7'b0100000, 7'b0101011); a_rs1 = 32'h1; a_rs2 = 32'h0;
    a_rdywr = 1'b0; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    a_rs1 = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_wr", 64'(a_wr), 64'd1);
      checkOutput("hold_rd", 64'(a_rd), 64'h2010);
      checkOutput("hold_wait", 64'(a_wait), 64'd1);
      checkOutput("hold_ready", 64'(a_ready), 64'd0);
      tick();
    end
    a_rdywr = 1'b1;
    #1;
    checkOutput("release_wait", 64'(a_wait), 64'd0);
    tick();
    checkOutput("release_ready", 64'(a_ready), 64'd1);
    checkOutput("release_wr", 64'(a_wr), 64'd0);

    $display("[TB] undecoded encodings");
    rejectA("idx5", mkInsn(7'b0000101, 7'b0101011));
    rejectA("rsv43", mkInsn(7'b0001000, 7'b0101011));
    rejectA("funct11", mkInsn(7'b1100000, 7'b0101011));
`ifdef COP_ISE_RV32B_EN
    applyStimulus("andnot", mkInsn(7'b0000001, 7'b1011011), 32'hFF00FF00, 32'h0F0F0F0F, 32'hF000F000);
    applyStimulus("iornot", mkInsn(7'b0000000, 7'b1011011), 32'h00000000, 32'hFFFF0000, 32'h0000FFFF);
    applyStimulus("rori_l", mkInsn(7'b0000100, 7'b0001011), 32'h00000001, 32'h0, 32'h10000000);
    applyStimulus("rori_h", mkInsn(7'b0101000, 7'b0001011), 32'h0, 32'h00000100, 32'h00000001);
`else
    rejectA("c2_nomacro", mkInsn(7'b0000001, 7'b1011011));
    rejectA("c0_nomacro", mkInsn(7'b0000100, 7'b0001011));
`endif

    $display("[TB] XLEN=64 LAT=3");
    b_insn = mkInsn(7'b0000010, 7'b0101011); b_rs1 = 64'h1; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("b_busy_wait", 64'(b_wait), 64'd1);
      checkOutput("b_busy_wr", 64'(b_wr), 64'd0);
      checkOutput("b_busy_ready", 64'(b_ready), 64'd0);
      tick();
    end
    checkOutput("b_done_wr", 64'(b_wr), 64'd1);
    checkOutput("b_done_rd", b_rd, 64'h8400000000000001);
    checkOutput("b_done_wait", 64'(b_wait), 64'd0);
    tick();
    checkOutput("b_idle_ready", 64'(b_ready), 64'd1);
    b_insn = mkInsn(7'b0000000, 7'b0101011); b_rs1 = 64'h1; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    tick();
    tick();
    checkOutput("b_sig0_rd", b_rd, 64'h0000201000000001);
    tick();
    b_insn = mkInsn(7'b0100000, 7'b0101011); b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("b_hi_rej_ready", 64'(b_ready), 64'd1);
      checkOutput("b_hi_rej_wr", 64'(b_wr), 64'd0);
    end
    b_valid = 1'b0;

    $display("[TB] XLEN=32 LAT=4 latency and mid-flight reset");
    c_insn = mkInsn(7'b0000000, 7'b0101011); c_rs1 = 32'h1; c_rs2 = 32'h0; c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("c_busy_wait", 64'(c_wait), 64'd1);
      checkOutput("c_busy_wr", 64'(c_wr), 64'd0);
      tick();
    end
    checkOutput("c_lat4_wr", 64'(c_wr), 64'd1);
    checkOutput("c_lat4_rd", 64'(c_rd), 64'h1);
    tick();
    c_insn = mkInsn(7'b0100000, 7'b0101011); c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    tick();
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    checkOutput("c_rst_ready", 64'(c_ready), 64'd1);
    checkOutput("c_rst_wait", 64'(c_wait), 64'd0);
    checkOutput("c_rst_wr", 64'(c_wr), 64'd0);
    checkOutput("c_rst_rd", 64'(c_rd), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("c_no_stale_wr", 64'(c_wr), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
